// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C bus arbiter slice.
// Holds the I2C word width, the codec device address used by the clients,
// and the arbiter FSM state encoding.
package i2c_pkg;

  localparam int         I2C_WORD_W = 24;
  localparam logic [7:0] CODEC_ADDR = 8'h34;

  typedef enum logic [2:0] {
    SETTLE,
    IDLE,
    LAUNCH,
    WAIT_BUSY,
    WAIT_DONE,
    RESPOND
  } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker.
// Ports:
//   req_i   - request vector, one bit per client
//   ptr_i   - index that has highest priority this round
//   found_o - at least one request is set
//   idx_o   - first set request at or after ptr_i, wrapping around
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic               found_o,
  output logic [IDX_W-1:0]   idx_o
);

  // Walk the offsets from farthest to nearest so the closest set bit
  // to ptr_i is the last one written and therefore wins.
  always_comb begin
    int             c;
    logic [IDX_W-1:0] cand;
    found_o = 1'b0;
    idx_o   = '0;
    c       = 0;
    cand    = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      c = int'(ptr_i) + k;
      if (c >= NUM_REQ) begin
        c = c - NUM_REQ;
      end
      cand = IDX_W'(c);
      if (req_i[cand]) begin
        found_o = 1'b1;
        idx_o   = cand;
      end
    end
  end

endmodule

// File: rtl/i2c_bus_arbiter.sv
// Shares one i2c_controller between NUM_REQ clients.
// Each grant performs one 24-bit write, retried on NACK up to MAX_RETRY
// extra times, guarded by a per-attempt watchdog.
// Ports:
//   clk, reset        - clock and synchronous active-high reset
//   req_i/req_data_i  - per-client request and 24-bit word (client i at [24i+:24])
//   gnt_o             - one-hot grant, held through the completion pulse
//   rsp_valid_o       - one-cycle completion pulse to the granted client
//   rsp_ok_o          - completion was an ACKed write
//   rsp_timeout_o     - completion failed on the watchdog
//   i2c_data_o        - word presented to the controller
//   i2c_start_o       - one-cycle start pulse to the controller
//   i2c_done_i        - controller idle/finished
//   i2c_ack_i         - slave ACK, valid while i2c_done_i is high after a transfer
//   busy_o            - arbiter is not idle
//   err_count_o       - saturating count of failed transactions
module i2c_bus_arbiter
  import i2c_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int MAX_RETRY      = 3,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_REQ-1:0]              req_i,
  input  logic [NUM_REQ*I2C_WORD_W-1:0]   req_data_i,
  output logic [NUM_REQ-1:0]              gnt_o,
  output logic [NUM_REQ-1:0]              rsp_valid_o,
  output logic                            rsp_ok_o,
  output logic                            rsp_timeout_o,
  output logic [I2C_WORD_W-1:0]           i2c_data_o,
  output logic                            i2c_start_o,
  input  logic                            i2c_done_i,
  input  logic                            i2c_ack_i,
  output logic                            busy_o,
  output logic [7:0]                      err_count_o
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int WD_W  = $clog2(TIMEOUT_CYCLES);
  localparam int RT_W  = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  localparam logic [WD_W-1:0]  WD_LAST   = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [RT_W-1:0]  RT_LAST   = RT_W'(MAX_RETRY);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_REQ - 1);

  arb_state_t                state_q, state_d;
  logic [IDX_W-1:0]          ptr_q, ptr_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic [I2C_WORD_W-1:0]     data_q, data_d;
  logic [NUM_REQ-1:0]        gnt_q, gnt_d;
  logic [RT_W-1:0]           retry_q, retry_d;
  logic [WD_W-1:0]           wd_q, wd_d;
  logic                      ok_q, ok_d;
  logic                      tmo_q, tmo_d;
  logic [7:0]                err_q, err_d;
  logic                      start_q, start_d;

  logic                      arb_found;
  logic [IDX_W-1:0]          arb_idx;
  logic [I2C_WORD_W-1:0]     sel_word;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .req_i   (req_i),
    .ptr_i   (ptr_q),
    .found_o (arb_found),
    .idx_o   (arb_idx)
  );

  // Word of the client the arbiter is currently pointing at.
  always_comb begin
    sel_word = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (IDX_W'(k) == arb_idx) begin
        sel_word = req_data_i[k*I2C_WORD_W +: I2C_WORD_W];
      end
    end
  end

  // State register. Reset lands in SETTLE so a controller transfer that
  // was in flight before reset is allowed to drain.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= SETTLE;
      ptr_q   <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      gnt_q   <= '0;
      retry_q <= '0;
      wd_q    <= '0;
      ok_q    <= 1'b0;
      tmo_q   <= 1'b0;
      err_q   <= '0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      gnt_q   <= gnt_d;
      retry_q <= retry_d;
      wd_q    <= wd_d;
      ok_q    <= ok_d;
      tmo_q   <= tmo_d;
      err_q   <= err_d;
      start_q <= start_d;
    end
  end

  // Next-state logic. The start pulse is registered out of LAUNCH, so it
  // appears the cycle after LAUNCH. In the wait states the watchdog check
  // comes first so the limit can never be skipped past.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    data_d  = data_q;
    gnt_d   = gnt_q;
    retry_d = retry_q;
    wd_d    = wd_q;
    ok_d    = ok_q;
    tmo_d   = tmo_q;
    err_d   = err_q;
    start_d = 1'b0;
    case (state_q)
      SETTLE: begin
        wd_d = wd_q + 1'b1;
        if (i2c_done_i || (wd_q == WD_LAST)) begin
          state_d = IDLE;
        end
      end
      IDLE: begin
        if (arb_found) begin
          idx_d          = arb_idx;
          data_d         = sel_word;
          gnt_d          = '0;
          gnt_d[arb_idx] = 1'b1;
          retry_d        = '0;
          ok_d           = 1'b0;
          tmo_d          = 1'b0;
          state_d        = LAUNCH;
        end
      end
      LAUNCH: begin
        start_d = 1'b1;
        wd_d    = '0;
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        wd_d = wd_q + 1'b1;
        if (wd_d == WD_LAST) begin
          ok_d    = 1'b0;
          tmo_d   = 1'b1;
          state_d = RESPOND;
        end else if (!i2c_done_i) begin
          state_d = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        wd_d = wd_q + 1'b1;
        if (wd_d == WD_LAST) begin
          ok_d    = 1'b0;
          tmo_d   = 1'b1;
          state_d = RESPOND;
        end else if (i2c_done_i) begin
          if (i2c_ack_i) begin
            ok_d    = 1'b1;
            state_d = RESPOND;
          end else if (retry_q != RT_LAST) begin
            retry_d = retry_q + 1'b1;
            state_d = LAUNCH;
          end else begin
            ok_d    = 1'b0;
            state_d = RESPOND;
          end
        end
      end
      RESPOND: begin
        gnt_d = '0;
        if (!ok_q && (err_q != 8'hFF)) begin
          err_d = err_q + 1'b1;
        end
        ptr_d   = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = SETTLE;
      end
    endcase
  end

  // Outputs. Completion flags are only visible during RESPOND.
  always_comb begin
    rsp_valid_o = '0;
    if (state_q == RESPOND) begin
      rsp_valid_o[idx_q] = 1'b1;
    end
    rsp_ok_o      = (state_q == RESPOND) && ok_q;
    rsp_timeout_o = (state_q == RESPOND) && tmo_q;
    gnt_o         = gnt_q;
    i2c_data_o    = data_q;
    i2c_start_o   = start_q;
    busy_o        = (state_q != IDLE);
    err_count_o   = err_q;
  end

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// Self-checking bench for i2c_bus_arbiter.
// A reference model predicts, per batch of requests, the service order,
// attempt count and outcome of every client; predictions go into a
// scoreboard queue that an independent monitor drains on rsp_valid.
// A controller model answers start pulses from a queue of planned attempts.
module tb_i2c_bus_arbiter;
  import i2c_pkg::*;

  localparam int NUM_REQ   = 4;
  localparam int MAX_RETRY = 3;
  localparam int TIMEOUT   = 50;

  logic                         clk;
  logic                         reset;
  logic [NUM_REQ-1:0]           req;
  logic [NUM_REQ*I2C_WORD_W-1:0] reqData;
  logic [NUM_REQ-1:0]           gnt;
  logic [NUM_REQ-1:0]           rspValid;
  logic                         rspOk;
  logic                         rspTimeout;
  logic [I2C_WORD_W-1:0]        i2cData;
  logic                         i2cStart;
  logic                         done;
  logic                         ack;
  logic                         busy;
  logic [7:0]                   errCount;

  i2c_bus_arbiter #(
    .NUM_REQ        (NUM_REQ),
    .MAX_RETRY      (MAX_RETRY),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .req_i         (req),
    .req_data_i    (reqData),
    .gnt_o         (gnt),
    .rsp_valid_o   (rspValid),
    .rsp_ok_o      (rspOk),
    .rsp_timeout_o (rspTimeout),
    .i2c_data_o    (i2cData),
    .i2c_start_o   (i2cStart),
    .i2c_done_i    (done),
    .i2c_ack_i     (ack),
    .busy_o        (busy),
    .err_count_o   (errCount)
  );

  typedef struct {
    int                    idx;
    logic [I2C_WORD_W-1:0] data;
    bit                    ok;
    bit                    tmo;
    int                    starts;
    int                    errAfter;
  } exp_t;

  typedef struct {
    bit ack;
    int len;
  } attempt_t;

  exp_t     expQ[$];
  attempt_t planQ[$];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  int                    modelPtr = 0;
  int                    modelErr = 0;
  logic [I2C_WORD_W-1:0] clientData[NUM_REQ];
  int                    clientNacks[NUM_REQ];
  bit                    clientHang[NUM_REQ];

  // Free-running clock and a cycle counter used for latency checks.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // Hard stop in case something upstream hangs despite the bounded waits.
  initial begin
    #500000;
    $display("[TB] FAIL global_timeout: simulation did not end, limit reached");
    $fatal(1, "[TB] global timeout");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Controller model: each start pops one planned attempt, drops done for
  // that many cycles, then raises done with the planned ACK value.
  initial begin
    int       busyCnt;
    bit       curAck;
    attempt_t p;
    done    = 1'b1;
    ack     = 1'b0;
    busyCnt = 0;
    curAck  = 1'b0;
    forever begin
      @(negedge clk);
      if (i2cStart) begin
        if (planQ.size() > 0) p = planQ.pop_front();
        else p = '{1'b1, 4};
        done    = 1'b0;
        ack     = 1'b0;
        busyCnt = p.len;
        curAck  = p.ack;
      end else if (busyCnt > 0) begin
        busyCnt--;
        if (busyCnt == 0) begin
          done = 1'b1;
          ack  = curAck;
        end
      end
    end
  end

  // Monitor: counts start pulses of the current transaction on its own and
  // compares each completion against the head of the scoreboard.
  initial begin
    int                    startCnt;
    int                    lastStart;
    logic [I2C_WORD_W-1:0] firstData;
    bit                    errPend;
    int                    errExp;
    exp_t                  e;
    startCnt  = 0;
    lastStart = 0;
    firstData = '0;
    errPend   = 1'b0;
    errExp    = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        startCnt = 0;
        errPend  = 1'b0;
      end else begin
        if (errPend) begin
          checkOutput("err_count", 32'(errCount), 32'(errExp));
          errPend = 1'b0;
        end
        if (i2cStart) begin
          if (startCnt == 0) firstData = i2cData;
          else checkOutput("retry_data", 32'(i2cData), 32'(firstData));
          startCnt++;
          lastStart = cyc;
        end
        if (rspValid != '0) begin
          if (expQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_rsp: got rsp_valid 0x%0h, expected none", rspValid);
          end else begin
            e = expQ.pop_front();
            checkOutput("rsp_valid", 32'(rspValid), 32'(1) << e.idx);
            checkOutput("gnt_at_rsp", 32'(gnt), 32'(1) << e.idx);
            checkOutput("rsp_ok", 32'(rspOk), 32'(e.ok));
            checkOutput("rsp_timeout", 32'(rspTimeout), 32'(e.tmo));
            checkOutput("start_count", 32'(startCnt), 32'(e.starts));
            checkOutput("i2c_data", 32'(firstData), 32'(e.data));
            if (e.tmo) checkOutput("wd_latency", 32'(cyc - lastStart), 32'(TIMEOUT - 1));
            errExp  = e.errAfter;
            errPend = 1'b1;
          end
          startCnt = 0;
        end
      end
    end
  end

  // Reference model: serve the batch in round-robin order from the model
  // pointer, deriving attempts and outcome from each client's NACK plan.
  task automatic predictBatch(input logic [NUM_REQ-1:0] mask);
    logic [NUM_REQ-1:0] m;
    int                 c;
    int                 attempts;
    exp_t               e;
    m = mask;
    while (m != '0) begin
      c = modelPtr;
      while (!m[c]) c = (c + 1) % NUM_REQ;
      e.idx  = c;
      e.data = clientData[c];
      if (clientHang[c]) begin
        e.ok     = 1'b0;
        e.tmo    = 1'b1;
        e.starts = 1;
        planQ.push_back('{1'b1, 70});
      end else begin
        attempts = (clientNacks[c] < MAX_RETRY + 1) ? clientNacks[c] + 1 : MAX_RETRY + 1;
        for (int a = 0; a < attempts; a++) begin
          planQ.push_back('{(a == clientNacks[c]), int'($urandom_range(2, 10))});
        end
        e.ok     = (clientNacks[c] <= MAX_RETRY);
        e.tmo    = 1'b0;
        e.starts = attempts;
      end
      if (!e.ok && modelErr < 255) modelErr++;
      e.errAfter = modelErr;
      expQ.push_back(e);
      m[c]     = 1'b0;
      modelPtr = (c + 1) % NUM_REQ;
    end
  endtask

  task automatic applyStimulus(input logic [NUM_REQ-1:0] mask);
    predictBatch(mask);
    for (int c = 0; c < NUM_REQ; c++) begin
      if (mask[c]) reqData[c*I2C_WORD_W +: I2C_WORD_W] = clientData[c];
    end
    req = req | mask;
  endtask

  // Drop each client's request on its completion pulse; bounded wait.
  task automatic waitBatch(input int budget, input bit checkLat);
    int cnt;
    cnt = 0;
    while (req != '0 && cnt < budget) begin
      @(negedge clk);
      cnt++;
      if (checkLat && cnt == 1) begin
        checkOutput("gnt_latency", 32'(gnt), 32'h1);
        checkOutput("start_not_yet", 32'(i2cStart), 32'h0);
      end
      if (checkLat && cnt == 2) begin
        checkOutput("start_latency", 32'(i2cStart), 32'h1);
        checkOutput("first_data", 32'(i2cData), 32'h340c10);
      end
      req = req & ~rspValid;
    end
    if (req != '0) begin
      checks++;
      errors++;
      $display("[TB] FAIL batch_timeout: req 0x%0h still pending after %0d cycles, expected 0x0", req, budget);
      req = '0;
      expQ.delete();
      planQ.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic clearPlans();
    for (int c = 0; c < NUM_REQ; c++) begin
      clientNacks[c] = 0;
      clientHang[c]  = 1'b0;
    end
  endtask

  initial begin
    int w;
    bit sawGnt;
    int n;
    reset   = 1'b1;
    req     = '0;
    reqData = '0;
    clearPlans();
    for (int c = 0; c < NUM_REQ; c++) clientData[c] = {CODEC_ADDR, 16'(c * 16'h1111)};
    repeat (3) @(negedge clk);
    checkOutput("reset_gnt", 32'(gnt), 32'h0);
    checkOutput("reset_rsp_valid", 32'(rspValid), 32'h0);
    checkOutput("reset_start", 32'(i2cStart), 32'h0);
    checkOutput("reset_err", 32'(errCount), 32'h0);
    checkOutput("reset_data", 32'(i2cData), 32'h0);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("idle_busy", 32'(busy), 32'h0);

    $display("[TB] single request");
    clientData[0] = 24'h340c10;
    applyStimulus(4'b0001);
    waitBatch(200, 1'b1);

    $display("[TB] contention and re-arbitration");
    applyStimulus(4'b1010);
    waitBatch(400, 1'b0);
    applyStimulus(4'b0010);
    waitBatch(200, 1'b0);
    applyStimulus(4'b0110);
    waitBatch(400, 1'b0);

    $display("[TB] retry then ACK");
    clientNacks[3] = 2;
    applyStimulus(4'b1000);
    waitBatch(300, 1'b0);

    $display("[TB] persistent NACK");
    clientNacks[0] = 9;
    applyStimulus(4'b0001);
    waitBatch(300, 1'b0);
    clearPlans();

    $display("[TB] watchdog");
    clientHang[1] = 1'b1;
    applyStimulus(4'b0010);
    waitBatch(200, 1'b0);
    clearPlans();
    repeat (40) @(negedge clk);

    $display("[TB] reset mid-transfer");
    planQ.push_back('{1'b1, 30});
    clientData[2] = 24'h34a55a;
    reqData[2*I2C_WORD_W +: I2C_WORD_W] = clientData[2];
    req = 4'b0100;
    w = 0;
    while (done && w < 20) begin
      @(negedge clk);
      w++;
    end
    checkOutput("transfer_started", 32'(done), 32'h0);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("abort_gnt", 32'(gnt), 32'h0);
    checkOutput("abort_rsp_valid", 32'(rspValid), 32'h0);
    checkOutput("abort_start", 32'(i2cStart), 32'h0);
    checkOutput("abort_err", 32'(errCount), 32'h0);
    reset    = 1'b0;
    modelPtr = 0;
    modelErr = 0;
    predictBatch(4'b0100);
    sawGnt = 1'b0;
    w = 0;
    while (!done && w < 60) begin
      if (gnt != '0 || rspValid != '0) sawGnt = 1'b1;
      @(negedge clk);
      w++;
    end
    checkOutput("settle_no_gnt", 32'(sawGnt), 32'h0);
    waitBatch(200, 1'b0);

    $display("[TB] randomized batches");
    for (int b = 0; b < 25; b++) begin
      for (int c = 0; c < NUM_REQ; c++) begin
        clientData[c] = {CODEC_ADDR, 16'($urandom)};
        n = int'($urandom_range(0, 9));
        clientNacks[c] = (n < 6) ? 0 : n - 5;
      end
      applyStimulus(4'($urandom_range(1, 15)));
      waitBatch(1000, 1'b0);
    end

    checkOutput("scoreboard_empty", 32'(expQ.size()), 32'h0);
    checkOutput("plan_empty", 32'(planQ.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
